// File: rtl/alu_pipe_if.sv
// Operand and result handshake bundle for alu_pipe.
// The master is the operand sequencer/result sink side; the slave is the ALU.
interface alu_pipe_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             cout;
    logic [3:0]       flags;

    modport master (
        output in_valid, a, b, c, out_ready,
        input  in_ready, out_valid, y, cout, flags
    );

    modport slave (
        input  in_valid, a, b, c, out_ready,
        output in_ready, out_valid, y, cout, flags
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes and a carry register
// that chains ADC/SBC across words in acceptance order.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    alu_pipe_if.slave  bus
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_ADC = 3'b110,
        OP_SBC = 3'b111
    } op_e;

    // Stage 0: operand register
    logic             s0_valid;
    logic [WIDTH-1:0] s0_a;
    logic [WIDTH-1:0] s0_b;
    op_e              s0_op;

    // Stage 1: result register
    logic             s1_valid;
    logic [WIDTH-1:0] s1_y;
    logic [3:0]       s1_flags;

    logic             cf;

    logic             s1_adv;
    logic             in_fire;
    logic             in_ready_int;

    logic             is_arith;
    logic             carry_in;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res_y;
    logic             res_c;
    logic             res_v;
    logic [3:0]       res_flags;

    assign s1_adv       = s0_valid && (!s1_valid || bus.out_ready);
    assign in_ready_int = !s0_valid || s1_adv;
    assign in_fire      = bus.in_valid && in_ready_int;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of process order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s0_valid <= 1'b0;
            // NOTE: operand fields are cleared only to keep the pipe X-free;
            // nothing downstream looks at them while s0_valid is low.
            s0_a     <= '0;
            s0_b     <= '0;
            s0_op    <= OP_ADD;
        end else if (in_fire) begin
            s0_valid <= 1'b1;
            s0_a     <= bus.a;
            s0_b     <= bus.b;
            s0_op    <= op_e'(bus.c);
        end else if (s1_adv) begin
            s0_valid <= 1'b0;
        end
    end

    // Subtract forms feed ~b to the adder; overflow is judged on those operands.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can infer a latch.
        is_arith = 1'b0;
        carry_in = 1'b0;
        add_b    = s0_b;
        res_y    = '0;
        res_c    = 1'b0;
        res_v    = 1'b0;

        case (s0_op)
            OP_ADD: begin
                is_arith = 1'b1;
            end
            OP_SUB: begin
                is_arith = 1'b1;
                add_b    = ~s0_b;
                carry_in = 1'b1;
            end
            OP_ADC: begin
                is_arith = 1'b1;
                carry_in = cf;
            end
            OP_SBC: begin
                is_arith = 1'b1;
                add_b    = ~s0_b;
                carry_in = cf;
            end
            default: begin
                is_arith = 1'b0;
            end
        endcase

        sum = {1'b0, s0_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, carry_in};

        case (s0_op)
            OP_AND:  res_y = s0_a & s0_b;
            OP_OR:   res_y = s0_a | s0_b;
            OP_XOR:  res_y = s0_a ^ s0_b;
            OP_SLT:  res_y = {{(WIDTH-1){1'b0}}, ($signed(s0_a) < $signed(s0_b))};
            default: begin
                res_y = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (s0_a[WIDTH-1] == add_b[WIDTH-1]) &&
                        (sum[WIDTH-1] != s0_a[WIDTH-1]);
            end
        endcase

        res_flags = {res_y[WIDTH-1], (res_y == '0), res_c, res_v};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_y     <= '0;
            s1_flags <= '0;
        end else if (s1_adv) begin
            s1_valid <= 1'b1;
            s1_y     <= res_y;
            s1_flags <= res_flags;
        end else if (bus.out_ready) begin
            s1_valid <= 1'b0;
        end
    end

    // Carry chains only through arithmetic ops, at the moment they leave s0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cf <= 1'b0;
        end else if (s1_adv && is_arith) begin
            cf <= res_c;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = s1_valid;
    assign bus.y         = s1_y;
    assign bus.flags     = s1_flags;
    assign bus.cout      = s1_flags[1];

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, two-stage pipelined successor to the combinational N-bit ALU. Width is configurable and the op set grows from 2-bit to 3-bit control, adding add/subtract-with-carry through an internal carry register for multi-word arithmetic. Operands and results move over valid/ready handshakes with full backpressure, one operation per cycle. The block sits between an operand sequencer and a result sink.

## Interface
- WIDTH, 8: operand/result width in bits, ≥2.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c  in  3  opcode.
- out_valid  out  1  result beat offered.
- out_ready  in  1  sink accepts the result this cycle.
- y  out  WIDTH  result.
- cout  out  1  equals flags[1].
- flags  out  4  {N,Z,C,V}, bit 3 = N.

## Operation
- Opcodes:
  - 000 ADD: a+b.
  - 001 SUB: a+~b+1.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLT: y = 1 if signed a<b, else 0.
  - 110 ADC: a+b+cf.
  - 111 SBC: a+~b+cf.
- Flags:
  - N = y[WIDTH-1].
  - Z = (y==0).
  - Arithmetic ops (000, 001, 110, 111): C = carry out of bit WIDTH-1. SUB/SBC carry means no borrow. V = signed overflow, i.e. operands entering the adder share a sign and the result sign differs.
  - Logic ops and SLT: C=0, V=0.
- cf: internal carry register.
  - Loaded with C only when an arithmetic op moves from stage 0 into stage 1.
  - Logic ops and SLT leave it unchanged.
  - Reset value 0.
- Stage 0 (s0): input register {a,b,c,valid}.
  - Loads when in_valid && in_ready.
  - Clears its valid bit when its beat moves on with no new beat arriving.
- Stage 1 (s1): compute plus output register {y,flags,valid}.
  - The result is computed from s0 contents and the current cf, then registered.
- Advance rules:
  - s1_adv = s0_valid && (!s1_valid || out_ready).
  - in_ready = !s0_valid || s1_adv. This is combinational from out_ready. There is no combinational path from in_valid to in_ready.
  - out_valid = s1_valid. y, flags and cout come straight from registers.
- Ordering: strictly in order. ADC/SBC always use the cf produced by the immediately preceding arithmetic op in acceptance order.
- Stability: while out_valid && !out_ready, y, flags and cout hold stable.

## Timing
- Latency: a beat accepted at edge k is presented at out_valid=1 after edge k+1. It is consumed at the first edge with out_ready=1.
- Throughput: 1 op/cycle while out_ready stays high.
- Buffering: with out_ready low, the pipe holds 2 beats. in_ready drops after the second acceptance.
- Simultaneous events: on the same edge, s1 may drain, s0 may shift into s1 and a new beat may load into s0, with no bubble.
- Reset values, applied immediately on reset=0 and independent of clk:
  - s0_valid = s1_valid = 0.
  - out_valid = 0.
  - y = 0, flags = 0000, cout = 0.
  - cf = 0.
  - in_ready = 1.
- Reset mid-operation: in-flight beats are discarded and none is emitted after release. Accepting resumes on the first rising edge with reset=1.

## Test plan
- ADD, WIDTH=8, a=0x7F, b=0x01, out_ready=1 -> two edges later y=0x80, flags=1001, cout=0.
- SUB, a=0x05, b=0x05 -> y=0x00, flags=0110. SLT, a=0x80, b=0x01 -> y=0x01, flags=0000, cf unchanged.
- Multi-word add, back-to-back:
  - ADD 0xFF+0x01 -> y=0x00, flags=0110 (cf=1).
  - ADC 0x00+0x00 -> y=0x01, flags=0000 (cf=0).
  - SBC 0x00-0x01 -> y=0xFE, flags=1000.
- Backpressure: hold out_ready=0 and offer 3 beats.
  - Only 2 are accepted and in_ready=0 from the second acceptance.
  - y and flags stay stable.
  - Raising out_ready drains the results in order, 1 per cycle, then the third beat is accepted.
- Reset mid-stream: assert reset=0 between edges with 2 beats in flight.
  - out_valid=0, y=0, flags=0000 and cf=0 immediately.
  - After release, ADC 0x01+0x01 -> y=0x02 (no carry-in).
- Streaming: 16 random beats with out_ready toggling randomly -> every result matches the reference model in order, and no beat is lost or duplicated.
